vga_vram_arbiter: RTL and testbench

//  Shares one single-port video RAM (1-cycle synchronous read) between the VGA scan-out path and the

---
 rtl/vga_vram_arbiter_if.sv | 24 ++
 rtl/vga_vram_arbiter.sv | 132 +++++++++++++
 tb/tb_vga_vram_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_vram_arbiter_if.sv
// Writer request/ack and VRAM bus bundle shared by the arbiter, the game-logic writer and the VRAM.
interface vga_vram_arbiter_if #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 24
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  wr_req, wr_addr, wr_data, mem_rdata,
    output wr_ack, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output wr_req, wr_addr, wr_data, mem_rdata,
    input  wr_ack, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: prefetches scan-out pixels into a small FIFO and hands
// spare memory cycles to the game-logic writer.
module vga_vram_arbiter #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LOW_WATER  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic              pix_en,
  output logic [DATA_W-1:0] pix_data,
  output logic              underflow,
  input  logic              clear_err,
  vga_vram_arbiter_if.slave bus
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [CW:0]       LOW_FILL  = (CW + 1)'(LOW_WATER);
  localparam logic [CW:0]       FULL_FILL = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_WAIT, S_FETCH, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic              inflight_q, inflight_d;
  logic [DATA_W-1:0] pix_q, pix_d;
  logic              underflow_q, underflow_d;
  logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_d [FIFO_DEPTH];

  logic [CW:0] fill;
  logic        fetching, rd_go, wr_go, push, pop;

  // Grant decision; everything is gated off while reset is held so the bus stays quiet.
  always_comb begin
    fill     = {1'b0, count_q} + (CW + 1)'(inflight_q);
    fetching = (state_q == S_FETCH);
    rd_go    = 1'b0;
    wr_go    = 1'b0;
    if (reset_n) begin
      if (frame_start)                           wr_go = bus.wr_req;
      else if (fetching && (fill <= LOW_FILL))   rd_go = 1'b1;
      else if (bus.wr_req)                       wr_go = 1'b1;
      else if (fetching && (fill < FULL_FILL))   rd_go = 1'b1;
    end
    bus.mem_we    = wr_go;
    bus.wr_ack    = wr_go;
    bus.mem_wdata = bus.wr_data;
    if (wr_go)      bus.mem_addr = bus.wr_addr;
    else if (rd_go) bus.mem_addr = fetch_addr_q;
    else            bus.mem_addr = mem_addr_q;
  end

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    mem_addr_d   = bus.mem_addr;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    pix_d        = pix_q;
    fifo_d       = fifo_q;
    inflight_d   = rd_go;

    // A return arriving in the frame_start cycle belongs to the old frame and is dropped.
    push = inflight_q && !frame_start;
    pop  = pix_en && (count_q != '0);

    if (pix_en) pix_d = pop ? fifo_q[rd_ptr_q] : '0;
    underflow_d = (pix_en && !pop) ? 1'b1 : (clear_err ? 1'b0 : underflow_q);

    if (push) begin
      fifo_d[wr_ptr_q] = bus.mem_rdata;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);

    if (rd_go) begin
      fetch_addr_d = fetch_addr_q + ADDR_W'(1);
      if (fetch_addr_q == LAST_ADDR) state_d = S_DONE;
    end

    if (frame_start) begin
      state_d      = S_FETCH;
      fetch_addr_d = '0;
      count_d      = '0;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_WAIT;
      fetch_addr_q <= '0;
      mem_addr_q   <= '0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      inflight_q   <= 1'b0;
      pix_q        <= '0;
      underflow_q  <= 1'b0;
      fifo_q       <= '{default: '0};
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      mem_addr_q   <= mem_addr_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      inflight_q   <= inflight_d;
      pix_q        <= pix_d;
      underflow_q  <= underflow_d;
      fifo_q       <= fifo_d;
    end
  end

  assign pix_data  = pix_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Bench for vga_vram_arbiter: queue-based reference model checked every cycle, plus directed scenarios.
module tb_vga_vram_arbiter;
  localparam int unsigned AW   = 4;
  localparam int unsigned DW   = 24;
  localparam int          NPIX = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          frame_start = 1'b0;
  logic          pix_en = 1'b0;
  logic          clear_err = 1'b0;
  logic [DW-1:0] pix_data;
  logic          underflow;

  int errors = 0;
  int checks = 0;

  vga_vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) vif ();

  vga_vram_arbiter #(
    .H_ACTIVE(8), .V_ACTIVE(2), .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4), .LOW_WATER(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .pix_en(pix_en),
    .pix_data(pix_data), .underflow(underflow), .clear_err(clear_err), .bus(vif.slave)
  );

  always #5 clk = ~clk;

  // VRAM: 1-cycle synchronous read, contents = address after reset.
  logic [DW-1:0] vram [NPIX];
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NPIX; i++) vram[i] <= DW'(i);
      vif.mem_rdata <= '0;
    end else begin
      if (vif.mem_we) vram[vif.mem_addr] <= vif.mem_wdata;
      vif.mem_rdata <= vram[vif.mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a pixel queue plus an in-flight slot, driven by the arbitration rules.
  bit            m_fetch;
  int            m_fa;
  logic [DW-1:0] mq [$];
  bit            m_inf;
  logic [DW-1:0] m_inf_data;
  logic [DW-1:0] m_pix;
  bit            m_under;
  int            m_last;
  logic [DW-1:0] mv [NPIX];

  always @(negedge clk) begin : cmp
    bit rd, wr, uset;
    int fill, exp_addr;
    if (!reset_n) begin
      m_fetch = 0; m_fa = 0; mq.delete(); m_inf = 0; m_inf_data = '0;
      m_pix = '0; m_under = 0; m_last = 0;
      for (int i = 0; i < NPIX; i++) mv[i] = DW'(i);
    end
    rd = 0; wr = 0; uset = 0;
    if (reset_n) begin
      fill = mq.size() + int'(m_inf);
      if (frame_start)                 wr = vif.wr_req;
      else if (m_fetch && fill <= 2)   rd = 1;
      else if (vif.wr_req)             wr = 1;
      else if (m_fetch && fill < 4)    rd = 1;
    end
    exp_addr = wr ? int'(vif.wr_addr) : (rd ? m_fa : m_last);
    check("mem_we", vif.mem_we, wr);
    check("wr_ack", vif.wr_ack, wr);
    check("mem_addr", vif.mem_addr, exp_addr);
    check("pix_data", pix_data, m_pix);
    check("underflow", underflow, m_under);
    if (wr) check("mem_wdata", vif.mem_wdata, vif.wr_data);
    if (reset_n) begin
      if (pix_en) begin
        if (mq.size() > 0) m_pix = mq.pop_front();
        else begin m_pix = '0; uset = 1; end
      end
      m_under = uset ? 1'b1 : (clear_err ? 1'b0 : m_under);
      if (m_inf && !frame_start) mq.push_back(m_inf_data);
      if (frame_start) begin mq.delete(); m_fa = 0; m_fetch = 1; end
      if (wr) begin mv[vif.wr_addr] = vif.wr_data; m_last = int'(vif.wr_addr); end
      if (rd) begin
        m_inf_data = mv[m_fa];
        m_last = m_fa;
        if (m_fa == NPIX - 1) m_fetch = 0;
        m_fa++;
      end
      m_inf = rd;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int t1_exp [6] = '{0, 1, 2, 3, 3, 3};

  initial begin
    int acks, ack_cyc;
    vif.wr_req = 1'b0; vif.wr_addr = '0; vif.wr_data = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

    // 1) frame_start with no pops: reads 0..3 then idle.
    frame_start = 1'b1;
    @(negedge clk);
    check("t1_fs_addr", vif.mem_addr, 0);
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t1_addr", vif.mem_addr, t1_exp[i]);
      check("t1_we", vif.mem_we, 0);
    end
    tick();

    // 2) pop every second cycle: whole frame in order, fetch stops at the last pixel.
    for (int i = 0; i < NPIX; i++) begin
      pix_en = 1'b1;
      tick();
      pix_en = 1'b0;
      check("t2_pix", pix_data, i);
      tick();
    end
    repeat (4) tick();
    check("t2_under", underflow, 0);
    check("t2_done_addr", vif.mem_addr, NPIX - 1);
    check("t2_done_we", vif.mem_we, 0);

    // 3) writer waits while the FIFO is below water.
    vif.wr_addr = AW'(9);
    vif.wr_data = 24'hABCDEF;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    vif.wr_req = 1'b1;
    acks = 0; ack_cyc = -1;
    for (int i = 2; i < 14; i++) begin
      @(negedge clk);
      if (vif.wr_ack) begin acks++; ack_cyc = i; end
      @(posedge clk);
      #1;
      if (acks > 0) vif.wr_req = 1'b0;
    end
    vif.wr_req = 1'b0;
    check("t3_acks", acks, 1);
    check("t3_ack_cycle", ack_cyc, 4);
    check("t3_vram", vram[9], 24'hABCDEF);

    // 4) pop straight after frame_start: empty pop.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    pix_en = 1'b1;
    tick();
    check("t4_under", underflow, 1);
    check("t4_pix", pix_data, 0);
    repeat (5) tick();
    pix_en = 1'b0;
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("t4_clear", underflow, 0);

    // 5) frame_start while a read is in flight.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (8) tick();
    pix_en = 1'b1;
    tick();
    check("t5_pop0", pix_data, 0);
    tick();
    check("t5_pop1", pix_data, 1);
    pix_en = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (6) tick();
    pix_en = 1'b1;
    tick();
    pix_en = 1'b0;
    check("t5_restart", pix_data, 0);

    // 6) reset mid-fetch with a pending write.
    pix_en = 1'b1;
    tick();
    pix_en = 1'b0;
    check("t6_pre_pix", pix_data, 1);
    tick();
    vif.wr_addr = AW'(3);
    vif.wr_req = 1'b1;
    reset_n = 1'b0;
    @(negedge clk);
    check("t6_we", vif.mem_we, 0);
    check("t6_ack", vif.wr_ack, 0);
    check("t6_pix", pix_data, 0);
    check("t6_addr", vif.mem_addr, 0);
    tick();
    reset_n = 1'b1;
    vif.wr_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t6_idle_addr", vif.mem_addr, 0);
      check("t6_idle_we", vif.mem_we, 0);
    end
    tick();
    vif.wr_req = 1'b1;
    @(negedge clk);
    check("t6_wait_ack", vif.wr_ack, 1);
    check("t6_wait_addr", vif.mem_addr, 3);
    tick();
    vif.wr_req = 1'b0;
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks);
    $fatal(1, "timeout");
  end

endmodule
